// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch and a load/store requester onto one shared memory port.
// A single transaction is in flight at a time; conflicts alternate, and data wins the first one after reset.
module memory_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LS_TYPE_WIDTH = 3,
  parameter logic [LS_TYPE_WIDTH-1:0] LS_TYPE_WORD = 3'b010,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Fetch_Valid,
  input  logic [XLEN-1:0]          i_Fetch_Addr,
  output logic                     o_Fetch_Ready,
  output logic [XLEN-1:0]          o_Fetch_Rdata,
  output logic                     o_Fetch_Rvalid,
  input  logic                     i_Data_Valid,
  input  logic                     i_Data_Write_Enable,
  input  logic [XLEN-1:0]          i_Data_Addr,
  input  logic [XLEN-1:0]          i_Data_Wdata,
  input  logic [LS_TYPE_WIDTH-1:0] i_Data_Load_Store_Type,
  output logic                     o_Data_Ready,
  output logic [XLEN-1:0]          o_Data_Rdata,
  output logic                     o_Data_Rvalid,
  output logic                     o_Mem_Enable,
  output logic                     o_Mem_Write_Enable,
  output logic [XLEN-1:0]          o_Mem_Addr,
  output logic [XLEN-1:0]          o_Mem_Wdata,
  output logic [LS_TYPE_WIDTH-1:0] o_Mem_Load_Store_Type,
  input  logic [XLEN-1:0]          i_Mem_Rdata,
  output logic [1:0]               o_Dbg_State
);

  // Handshake: a request transfers on the rising edge where valid && ready are both high; the requester
  // holds valid and payload stable until then. Ready rises only in IDLE, toward the granted requester.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  state_e                   state_q, state_d;
  logic                     last_data_q, last_data_d;
  logic                     is_data_q, is_data_d;
  logic                     is_write_q, is_write_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [LS_TYPE_WIDTH-1:0] type_q, type_d;
  logic [XLEN-1:0]          fetch_rdata_q, fetch_rdata_d;
  logic [XLEN-1:0]          data_rdata_q, data_rdata_d;
  logic                     fetch_rvalid_q, fetch_rvalid_d;
  logic                     data_rvalid_q, data_rvalid_d;

  logic grant_data, grant_fetch, fetch_ready, data_ready;

  // On a conflict the requester that was not granted last wins.
  assign grant_data  = i_Data_Valid & (~i_Fetch_Valid | ~last_data_q);
  assign grant_fetch = i_Fetch_Valid & ~grant_data;
  assign fetch_ready = (state_q == ST_IDLE) & ~i_Reset & grant_fetch;
  assign data_ready  = (state_q == ST_IDLE) & ~i_Reset & grant_data;

  always_comb begin
    state_d        = state_q;
    last_data_d    = last_data_q;
    is_data_d      = is_data_q;
    is_write_d     = is_write_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    type_d         = type_q;
    fetch_rdata_d  = fetch_rdata_q;
    data_rdata_d   = data_rdata_q;
    fetch_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_ready) begin
          state_d     = ST_ISSUE;
          last_data_d = 1'b1;
          is_data_d   = 1'b1;
          is_write_d  = i_Data_Write_Enable;
          addr_d      = i_Data_Addr;
          wdata_d     = i_Data_Wdata;
          type_d      = i_Data_Load_Store_Type;
        end else if (fetch_ready) begin
          state_d     = ST_ISSUE;
          last_data_d = 1'b0;
          is_data_d   = 1'b0;
          is_write_d  = 1'b0;
          addr_d      = i_Fetch_Addr;
          wdata_d     = '0;
          type_d      = LS_TYPE_WORD;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = is_write_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          if (is_data_q) begin
            data_rdata_d  = i_Mem_Rdata;
            data_rvalid_d = 1'b1;
          end else begin
            fetch_rdata_d  = i_Mem_Rdata;
            fetch_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q        <= ST_IDLE;
      last_data_q    <= 1'b0;
      is_data_q      <= 1'b0;
      is_write_q     <= 1'b0;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      type_q         <= '0;
      fetch_rdata_q  <= '0;
      data_rdata_q   <= '0;
      fetch_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_data_q    <= last_data_d;
      is_data_q      <= is_data_d;
      is_write_q     <= is_write_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      type_q         <= type_d;
      fetch_rdata_q  <= fetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
    end
  end

  assign o_Fetch_Ready         = fetch_ready;
  assign o_Data_Ready          = data_ready;
  assign o_Fetch_Rdata         = fetch_rdata_q;
  assign o_Fetch_Rvalid        = fetch_rvalid_q;
  assign o_Data_Rdata          = data_rdata_q;
  assign o_Data_Rvalid         = data_rvalid_q;
  assign o_Mem_Enable          = (state_q == ST_ISSUE);
  assign o_Mem_Write_Enable    = (state_q == ST_ISSUE) & is_write_q;
  assign o_Mem_Addr            = addr_q;
  assign o_Mem_Wdata           = wdata_q;
  assign o_Mem_Load_Store_Type = type_q;
  assign o_Dbg_State           = state_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and data width.
REQ-002 The block SHALL have parameter LS_TYPE_WIDTH, default 3, meaning the load/store type width.
REQ-003 The block SHALL have parameter LS_TYPE_WORD, default 3'b010, meaning the type code driven for fetches.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, meaning the memory read latency in cycles (>=1).
REQ-005 The block SHALL have port i_Clock  input  1  the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have ports i_Fetch_Valid in 1, i_Fetch_Addr in XLEN, o_Fetch_Ready out 1, o_Fetch_Rdata out XLEN, o_Fetch_Rvalid out 1: the instruction-fetch requester.
REQ-008 The block SHALL have ports i_Data_Valid in 1, i_Data_Write_Enable in 1, i_Data_Addr in XLEN, i_Data_Wdata in XLEN, i_Data_Load_Store_Type in LS_TYPE_WIDTH, o_Data_Ready out 1, o_Data_Rdata out XLEN, o_Data_Rvalid out 1: the load/store requester.
REQ-009 The block SHALL have ports o_Mem_Enable out 1, o_Mem_Write_Enable out 1, o_Mem_Addr out XLEN, o_Mem_Wdata out XLEN, o_Mem_Load_Store_Type out LS_TYPE_WIDTH, i_Mem_Rdata in XLEN: the single shared memory port.

Function
REQ-010 The block SHALL use states IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-011 A request SHALL be accepted in the cycle where valid and ready are both high; requesters hold valid and payload stable until accepted.
REQ-012 Ready SHALL be asserted only in IDLE and only for the granted requester; ready may depend combinationally on both valids.
REQ-013 In IDLE, when only one valid is high, that requester SHALL be granted.
REQ-014 In IDLE, when both valids are high, the requester not granted last SHALL be granted; after reset, data wins the first conflict.
REQ-015 The last-grant register SHALL update only on acceptance.
REQ-016 On acceptance, the block SHALL register addr, wdata, write enable and type into the o_Mem_* outputs, and the state SHALL go to ISSUE.
REQ-017 A fetch SHALL drive o_Mem_Write_Enable=0, o_Mem_Wdata=0 and o_Mem_Load_Store_Type=LS_TYPE_WORD.
REQ-018 In ISSUE, o_Mem_Enable SHALL be 1 for exactly one cycle, and o_Mem_Write_Enable SHALL equal the accepted write flag.
REQ-019 Outside ISSUE, o_Mem_Enable and o_Mem_Write_Enable SHALL be 0, and o_Mem_Addr, o_Mem_Wdata and o_Mem_Load_Store_Type SHALL hold their last values.
REQ-020 After ISSUE, a write SHALL return to IDLE with no Rvalid, so a write accepted in cycle 0 allows the next acceptance in cycle 2.
REQ-021 After ISSUE, a read SHALL enter WAIT and count READ_LATENCY cycles.
REQ-022 In the final WAIT cycle, the block SHALL capture i_Mem_Rdata into the granted requester's Rdata register and go to IDLE.
REQ-023 A read accepted in cycle 0 SHALL give Rvalid high for exactly one cycle in cycle READ_LATENCY+2.
REQ-024 Ready for the next request SHALL be available in that same cycle as Rvalid.
REQ-025 o_*_Rdata SHALL hold its value until the next read for the same requester completes.
REQ-026 Only the requester that issued the read SHALL see Rvalid.
REQ-027 Addresses and data SHALL pass unmodified, with no alignment checking.
REQ-028 The WAIT counter SHALL be wide enough for READ_LATENCY and SHALL reset to 0 on each ISSUE.

Reset
REQ-029 While i_Reset is high, the state SHALL be IDLE and the last-grant register SHALL select fetch, so data wins next.
REQ-030 While i_Reset is high, o_Mem_Enable, o_Mem_Write_Enable, o_Fetch_Rvalid and o_Data_Rvalid SHALL be 0.
REQ-031 While i_Reset is high, o_Mem_Addr, o_Mem_Wdata, o_Mem_Load_Store_Type, o_Fetch_Rdata and o_Data_Rdata SHALL be 0, and both readies SHALL be 0.
REQ-032 Reset during ISSUE or WAIT SHALL abort the transaction: no Rvalid, no Rdata update, and no further o_Mem_Enable.
REQ-033 On the first clock edge after reset deasserts, the block SHALL be in IDLE and able to accept.

Verification (READ_LATENCY=1)
REQ-034 Single fetch: Fetch_Valid, addr 0x10 accepted in cycle 0, mem returns 0x00500093 -> o_Mem_Enable and addr 0x10 with type 010 in cycle 1; Fetch_Rvalid, Rdata 0x00500093 in cycle 3; Fetch_Ready in cycle 3.
REQ-035 Simultaneous requests after reset: fetch 0x0 and data read 0x100 -> data granted first, fetch granted on the next acceptance; second conflict grants data again only if fetch was last.
REQ-036 Store: data write addr 0x200, wdata 0xDEADBEEF, type 010 -> cycle 1 has Mem_Enable=1 and Mem_Write_Enable=1; no Data_Rvalid; Data_Ready in cycle 2.
REQ-037 Back-to-back fetches with Data_Valid low -> one acceptance every 3 cycles; Mem_Enable is never high in consecutive cycles.
REQ-038 Reset mid-read: assert i_Reset during WAIT -> outputs go to reset values asynchronously; no Rvalid in the following 5 cycles; a new fetch completes normally.
REQ-039 Data read with Data_Valid held 4 cycles before ready (fetch in flight) -> payload accepted exactly once, and the returned Rdata matches memory.
